trigger_sequencer: RTL
======================

Name: trigger_sequencer

Overview:
Controller that sequences the trigger stages of the logic analyzer core. Arms the stage array, enables only the stages whose configured level equals the current trigger level, and advances the level on matches. On a match from a start-stage it counts down that stage's delay and issues a single run pulse to the sampler/memory controller. Sits between the command decoder (arm/abort) and the stage array.

Parameters:
NUM_STAGES, 4, number of trigger stages sequenced (1..8)
LVL_W, 2, width of the trigger level field
DLY_W, 16, width of the per-stage delay field

Ports:
clk_i  in  1  system clock
rst_in  in  1  asynchronous active-low reset
arm_i  in  1  arm command pulse from command decoder
abort_i  in  1  abort/reset command pulse; returns to IDLE
stg_match_i  in  NUM_STAGES  per-stage match, registered by the stages
stg_level_i  in  NUM_STAGES*LVL_W  per-stage configured level, stage i at [i*LVL_W +: LVL_W]
stg_start_i  in  NUM_STAGES  per-stage start flag (1 = match fires capture)
stg_delay_i  in  NUM_STAGES*DLY_W  per-stage delay, stage i at [i*DLY_W +: DLY_W]
stg_en_o  out  NUM_STAGES  stage enable; stage i active when high
level_o  out  LVL_W  current trigger level
armed_o  out  1  high in ARMED and DELAY
run_o  out  1  one-cycle capture-start pulse
fired_o  out  1  high in FIRED until next arm/abort

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE, level_o=0, delay counter 0, stg_en_o=0, armed_o=0, run_o=0, fired_o=0.
- States: IDLE, ARMED, DELAY, FIRED; all registered.
- IDLE: arm_i -> ARMED, level cleared to 0.
- ARMED: stg_en_o[i] = (stg_level_i[i] == level_o), combinational from registered level; 0 in all other states. Only matches with stg_en_o[i]=1 are qualified.
  - any qualified match with stg_start_i=1 -> lowest-indexed such stage wins; counter loaded with its delay; next state DELAY if delay != 0, else FIRED with run_o=1 on the transition cycle's next edge.
  - else any qualified match (start=0) -> level_o increments by 1, saturating at 2^LVL_W-1; state stays ARMED. Multiple qualified non-start matches in one cycle increment once.
  - start match takes priority over level advance in the same cycle.
- DELAY: counter decrements each cycle; at counter==1 -> next state FIRED, run_o asserted for exactly one cycle on entry to FIRED. Matches ignored.
- Latency: qualified start match sampled at edge t -> run_o high during cycle t+1+delay (delay 0 -> cycle t+1).
- FIRED: fired_o=1, holds until arm_i (-> ARMED, level 0) or abort_i (-> IDLE).
- abort_i in any state -> IDLE next edge, counter cleared, run_o not asserted; abort_i wins over simultaneous arm_i and over a same-cycle start match.
- arm_i in ARMED or DELAY re-arms: level 0, counter cleared, state ARMED.
- Asynchronous reset mid-DELAY drops run_o/armed_o immediately; no pending pulse after release.
- Config inputs are sampled only on the match cycle; changes during DELAY do not affect the running count.

Optional Feature:
TRG_EXT_TRIGGER_EN: adds input ext_trg_i (1). When defined, ext_trg_i high in ARMED is treated as a start match with delay 0 and lower priority than any qualified stage start match; run_o follows in cycle t+1. When undefined, port absent, behaviour as above.

Test Plan:
- Reset/idle: rst_in low mid-run -> all outputs 0; matches with no arm_i -> stg_en_o=0, run_o never high.
- Single stage: stage0 level 0, start=1, delay 0; arm, match at edge t -> run_o pulse exactly at t+1, fired_o=1 afterwards, level_o=0.
- Multi-level: stage0 level0 start0, stage1 level1 start1 delay 5; match0 -> level_o=1, stg_en_o=4'b0010; match1 at t -> run_o at t+6, single cycle.
- Priority: stage2 (delay 3) and stage1 (delay 7) both start at level0 match same cycle -> stage1 wins, run_o at t+8; non-start + start same cycle -> no level advance.
- Abort/re-arm: abort_i during DELAY with 4 cycles left -> IDLE, no run_o; arm_i during DELAY -> ARMED, level 0, count restarts only on new match.
- Saturation: LVL_W=2, four successive non-start matches at levels 0..3 -> level_o stops at 3, no wrap to 0.

Source files
------------

// File: rtl/trigger_sequencer.sv
// -----------------------------------------------------------------------------
// trigger_sequencer
//
// Sequences the trigger stages of the logic analyzer core. After an arm command
// it enables only the stages whose configured level equals the current trigger
// level. A qualified non-start match advances the level. A qualified start
// match loads that stage's delay, counts it down and then issues one run pulse
// to the sampler/memory controller.
//
// Optional feature (define TRG_EXT_TRIGGER_EN): adds ext_trg_i. When armed,
// ext_trg_i acts as a start match with zero delay. It ranks below any
// qualified stage start match.
//
// Ports:
//   clk_i        system clock
//   rst_in       asynchronous active-low reset
//   ext_trg_i    external trigger (only with TRG_EXT_TRIGGER_EN)
//   arm_i        arm command pulse (also re-arms from ARMED/DELAY/FIRED)
//   abort_i      abort command pulse; returns to IDLE, beats arm_i and matches
//   stg_match_i  per-stage registered match
//   stg_level_i  per-stage level, stage i at [i*LVL_W +: LVL_W]
//   stg_start_i  per-stage start flag (match fires capture)
//   stg_delay_i  per-stage delay, stage i at [i*DLY_W +: DLY_W]
//   stg_en_o     per-stage enable, only in ARMED
//   level_o      current trigger level
//   armed_o      high in ARMED and DELAY
//   run_o        one-cycle capture-start pulse on entry to FIRED
//   fired_o      high in FIRED
// -----------------------------------------------------------------------------
module trigger_sequencer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned LVL_W      = 2,
  parameter int unsigned DLY_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_in,
`ifdef TRG_EXT_TRIGGER_EN
  input  logic                        ext_trg_i,
`endif
  input  logic                        arm_i,
  input  logic                        abort_i,
  input  logic [NUM_STAGES-1:0]       stg_match_i,
  input  logic [NUM_STAGES*LVL_W-1:0] stg_level_i,
  input  logic [NUM_STAGES-1:0]       stg_start_i,
  input  logic [NUM_STAGES*DLY_W-1:0] stg_delay_i,
  output logic [NUM_STAGES-1:0]       stg_en_o,
  output logic [LVL_W-1:0]            level_o,
  output logic                        armed_o,
  output logic                        run_o,
  output logic                        fired_o
);

  typedef enum logic [1:0] {StIdle, StArmed, StDelay, StFired} state_e;

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;

  logic [NUM_STAGES-1:0] stg_en;
  logic [NUM_STAGES-1:0] qual;
  logic [NUM_STAGES-1:0] qual_start;
  logic                  start_found;
  logic [DLY_W-1:0]      start_dly;
  logic                  ext_trg;

`ifdef TRG_EXT_TRIGGER_EN
  assign ext_trg = ext_trg_i;
`else
  assign ext_trg = 1'b0;
`endif

  // Stage enables come from the registered level, so they settle one cycle
  // after each level change.
  always_comb begin
    stg_en = '0;
    if (state_q == StArmed) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stg_en[i] = (stg_level_i[i*LVL_W +: LVL_W] == level_q);
      end
    end
  end

  assign qual       = stg_match_i & stg_en;
  assign qual_start = qual & stg_start_i;

  // Lowest-indexed qualified start stage wins.
  always_comb begin
    start_found = 1'b0;
    start_dly   = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (qual_start[i] && !start_found) begin
        start_found = 1'b1;
        start_dly   = stg_delay_i[i*DLY_W +: DLY_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    run_d   = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
      level_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm_i) begin
            state_d = StArmed;
            level_d = '0;
          end
        end
        StArmed: begin
          if (arm_i) begin
            level_d = '0;
            cnt_d   = '0;
          end else if (start_found) begin
            cnt_d = start_dly;
            if (start_dly == '0) begin
              state_d = StFired;
              run_d   = 1'b1;
            end else begin
              state_d = StDelay;
            end
          end else if (ext_trg) begin
            state_d = StFired;
            run_d   = 1'b1;
            cnt_d   = '0;
          end else if (|qual) begin
            // Saturate at the top level; several matches still advance once.
            if (level_q != {LVL_W{1'b1}}) begin
              level_d = level_q + LVL_W'(1);
            end
          end
        end
        StDelay: begin
          if (arm_i) begin
            state_d = StArmed;
            level_d = '0;
            cnt_d   = '0;
          end else if (cnt_q <= DLY_W'(1)) begin
            state_d = StFired;
            run_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end
        StFired: begin
          if (arm_i) begin
            state_d = StArmed;
            level_d = '0;
          end
        end
        default: begin
          state_d = StIdle;
          level_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      level_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  assign stg_en_o = stg_en;
  assign level_o  = level_q;
  assign armed_o  = (state_q == StArmed) || (state_q == StDelay);
  assign run_o    = run_q;
  assign fired_o  = (state_q == StFired);

endmodule
